hd_program_loader: RTL and testbench
====================================

Name: hd_program_loader

Overview:
- DMA-style sequencer that copies one program file from the simulated HD into instruction memory for the OS process launcher.
- Scans the HD from address 0, counts file headers to find the file with the requested index, then streams it word-for-word to memory at a caller-supplied base.
- Sits between the OS control unit (start/file_id requester) and the HD read port plus the instruction-memory write port.

Parameters:
- DATA_WIDTH, 32, HD word and memory word width.
- HD_ADDR_WIDTH, 9, HD address width.
- MEM_ADDR_WIDTH, 10, instruction-memory address width.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle load request; sampled only in IDLE.
- file_id  input  8  zero-based index of the file to load.
- dest_base  input  MEM_ADDR_WIDTH  memory address for the file's first word.
- hd_addr  output  HD_ADDR_WIDTH  HD read address.
- hd_q  input  DATA_WIDTH  HD read data, valid one clk after hd_addr.
- hd_we_snoop  input  1  HD write strobe; used by the optional feature only.
- mem_addr  output  MEM_ADDR_WIDTH  memory write address.
- mem_data  output  DATA_WIDTH  memory write data.
- mem_we  output  1  memory write strobe.
- busy  output  1  high from the cycle after start is accepted until done or error.
- done  output  1  one-cycle pulse on successful completion.
- error  output  3  0 none, 1 not found, 2 malformed, 3 memory overflow, 4 HD address exhausted; held until the next start.
- word_count  output  MEM_ADDR_WIDTH+1  number of words written.
- file_start_addr  output  HD_ADDR_WIDTH  HD address of the loaded file's header.

Behaviour:
- Markers use hd_q[31:26]: BEGIN=6'b010101, END=6'b010110, HD_END=6'b011000.
- Reset values: all outputs 0; FSM in IDLE. An asynchronous reset mid-load aborts immediately; memory contents are left partial.
- FSM states: IDLE -> SCAN -> COPY -> FINISH -> IDLE. Any state except IDLE goes to FAULT on error; FAULT -> IDLE next cycle.
- IDLE: on start, latch file_id and dest_base, clear the header counter, word_count and error, set hd_addr=0, enter SCAN. start while busy is ignored.
- Read pipeline: in SCAN and COPY, hd_addr increments by 1 every clk. A valid bit follows the address by one clk, and hd_q is evaluated when valid=1.
- SCAN, on each evaluated word:
  - BEGIN with counter==file_id: capture file_start_addr, write the word to dest_base, go to COPY.
  - BEGIN otherwise: counter+1.
  - HD_END: error=1.
- COPY:
  - Each evaluated word is written (mem_we=1) to dest_base+offset in the same cycle it is evaluated; word_count increments.
  - The END word is written, then the FSM goes to FINISH. The one prefetched read already in flight is discarded.
  - BEGIN or HD_END seen inside the file: error=2, not written.
- Overflow: a write whose address would wrap past 2^MEM_ADDR_WIDTH-1 gives error=3 and no write.
- HD exhaustion: when hd_addr reaches 2^HD_ADDR_WIDTH-1 and that word is evaluated without terminating, error=4.
- FINISH: done=1 for one clk, busy=0.
- On error: error is set, busy=0, no done pulse.
- Latency:
  - SCAN evaluates HD address a at start_edge+a+2.
  - Total load time is file_start_addr+word_count+2 clks from start to the done pulse.

Optional Feature:
- Macro: HD_LOADER_DIR_CACHE_EN.
- Defined:
  - Adds a 4-entry directory cache indexed by file_id[1:0], each entry holding {valid, tag=file_id[7:2], hd_addr}.
  - Entries are filled on every BEGIN passed or matched during SCAN.
  - On start with a hit, SCAN begins at the cached address with the counter preset to file_id, so the header is found on the first evaluated word.
  - Any hd_we_snoop=1 clears all valid bits in the same cycle and has priority over a simultaneous fill.
- Undefined: hd_we_snoop is ignored and every load scans from address 0.

Test Plan:
- Boot image (headers at 0, 58, 83; HD_END at 116); start, file_id=0, dest_base=0 -> 58 writes, mem[0]=0x54000000, mem[57]=0x58000039; done at start+60; word_count=58; file_start_addr=0.
- Same image, file_id=2, dest_base=200 -> mem[200..232] written, word_count=33, file_start_addr=83, error=0.
- file_id=3 -> scan reaches addr 116, error=1, busy drops, no done pulse, no mem_we.
- MEM_ADDR_WIDTH=6, file_id=0, dest_base=40 -> 24 writes (addresses 40..63), then error=3.
- Assert reset during COPY of file 1, then release and start file_id=1 -> clean reload with word_count=25 and done pulse; a start pulse while busy is ignored.
- With HD_LOADER_DIR_CACHE_EN: load file 2 twice; the second done comes 83 clks sooner. Pulse hd_we_snoop, load again -> original latency restored.

Source files
------------

// File: rtl/hd_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : hd_program_loader
// Brief    : Finds the file_id-th program on the HD and copies it to memory.
//            Optional directory cache enabled by HD_LOADER_DIR_CACHE_EN.
// Revision : 1.0
// ============================================================================
module hd_program_loader #(
  parameter int DATA_WIDTH     = 32,
  parameter int HD_ADDR_WIDTH  = 9,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [7:0]                file_id,
  input  logic [MEM_ADDR_WIDTH-1:0] dest_base,
  output logic [HD_ADDR_WIDTH-1:0]  hd_addr,
  input  logic [DATA_WIDTH-1:0]     hd_q,
  input  logic                      hd_we_snoop,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      mem_we,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                error,
  output logic [MEM_ADDR_WIDTH:0]   word_count,
  output logic [HD_ADDR_WIDTH-1:0]  file_start_addr
);

  localparam logic [5:0] c_MARK_BEGIN  = 6'b010101;
  localparam logic [5:0] c_MARK_END    = 6'b010110;
  localparam logic [5:0] c_MARK_HD_END = 6'b011000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_COPY   = 3'd2,
    S_FINISH = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                    r_state, w_next;
  logic [7:0]                r_file_id, r_count, w_start_count;
  logic [MEM_ADDR_WIDTH-1:0] r_dest_base;
  logic [HD_ADDR_WIDTH-1:0]  r_hd_addr, r_eval_addr, r_fsa, w_start_addr;
  logic                      r_valid;
  logic [MEM_ADDR_WIDTH:0]   r_word_count, w_wr_addr_ext;
  logic [2:0]                r_error, w_err;
  logic                      w_we, w_capture, w_count_inc, w_overflow, w_last;
  logic [5:0]                w_marker;

  assign w_marker      = hd_q[DATA_WIDTH-1 -: 6];
  assign w_wr_addr_ext = {1'b0, r_dest_base} + r_word_count;
  assign w_overflow    = w_wr_addr_ext[MEM_ADDR_WIDTH];
  assign w_last        = (r_eval_addr == {HD_ADDR_WIDTH{1'b1}});

`ifdef HD_LOADER_DIR_CACHE_EN
  logic [3:0]                     r_dc_valid;
  logic [3:0][5:0]                r_dc_tag;
  logic [3:0][HD_ADDR_WIDTH-1:0]  r_dc_addr;
  logic                           w_dc_hit, w_fill;

  assign w_dc_hit = r_dc_valid[file_id[1:0]] && (r_dc_tag[file_id[1:0]] == file_id[7:2])
                    && !hd_we_snoop;
  // Every header seen while scanning is recorded, whether skipped or matched.
  assign w_fill   = (r_state == S_SCAN) && r_valid && (w_marker == c_MARK_BEGIN);
  assign w_start_addr  = w_dc_hit ? r_dc_addr[file_id[1:0]] : '0;
  assign w_start_count = w_dc_hit ? file_id : 8'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dc_valid <= '0;
      r_dc_tag   <= '0;
      r_dc_addr  <= '0;
    end else if (hd_we_snoop) begin
      r_dc_valid <= '0;
    end else if (w_fill) begin
      r_dc_valid[r_count[1:0]] <= 1'b1;
      r_dc_tag[r_count[1:0]]   <= r_count[7:2];
      r_dc_addr[r_count[1:0]]  <= r_eval_addr;
    end
  end
`else
  logic w_unused_snoop;
  assign w_unused_snoop = hd_we_snoop;
  assign w_start_addr   = '0;
  assign w_start_count  = 8'd0;
`endif

  always_comb begin
    w_next      = r_state;
    w_we        = 1'b0;
    w_capture   = 1'b0;
    w_count_inc = 1'b0;
    w_err       = 3'd0;
    case (r_state)
      S_IDLE: if (start) w_next = S_SCAN;
      S_SCAN: begin
        if (r_valid) begin
          if (w_marker == c_MARK_HD_END) begin
            w_err = 3'd1;
          end else if (w_marker == c_MARK_BEGIN && r_count == r_file_id) begin
            w_we      = 1'b1;
            w_capture = 1'b1;
            w_next    = S_COPY;
            if (w_last) w_err = 3'd4;
          end else begin
            w_count_inc = (w_marker == c_MARK_BEGIN);
            if (w_last) w_err = 3'd4;
          end
        end
      end
      S_COPY: begin
        if (r_valid) begin
          if (w_marker == c_MARK_BEGIN || w_marker == c_MARK_HD_END) begin
            w_err = 3'd2;
          end else if (w_overflow) begin
            w_err = 3'd3;
          end else begin
            w_we = 1'b1;
            if (w_marker == c_MARK_END) w_next = S_FINISH;
            else if (w_last)            w_err  = 3'd4;
          end
        end
      end
      S_FINISH: w_next = S_IDLE;
      S_FAULT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_err != 3'd0) w_next = S_FAULT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_file_id    <= '0;
      r_dest_base  <= '0;
      r_count      <= '0;
      r_hd_addr    <= '0;
      r_eval_addr  <= '0;
      r_valid      <= 1'b0;
      r_word_count <= '0;
      r_fsa        <= '0;
      r_error      <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_valid <= 1'b0;
        if (start) begin
          r_file_id    <= file_id;
          r_dest_base  <= dest_base;
          r_count      <= w_start_count;
          r_word_count <= '0;
          r_error      <= '0;
          r_hd_addr    <= w_start_addr;
        end
      end else if (r_state == S_SCAN || r_state == S_COPY) begin
        r_hd_addr   <= r_hd_addr + HD_ADDR_WIDTH'(1);
        r_eval_addr <= r_hd_addr;
        // The read in flight when leaving COPY/SCAN is dropped here.
        r_valid     <= (w_next == S_SCAN) || (w_next == S_COPY);
        if (w_count_inc)    r_count      <= r_count + 8'd1;
        if (w_we)           r_word_count <= r_word_count + (MEM_ADDR_WIDTH+1)'(1);
        if (w_capture)      r_fsa        <= r_eval_addr;
        if (w_err != 3'd0)  r_error      <= w_err;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign hd_addr         = r_hd_addr;
  assign mem_addr        = w_wr_addr_ext[MEM_ADDR_WIDTH-1:0];
  assign mem_data        = w_we ? hd_q : '0;
  assign mem_we          = w_we;
  assign busy            = (r_state == S_SCAN) || (r_state == S_COPY);
  assign done            = (r_state == S_FINISH);
  assign error           = r_error;
  assign word_count      = r_word_count;
  assign file_start_addr = r_fsa;

endmodule
`default_nettype wire

// File: tb/tb_hd_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hd_program_loader
// Brief    : Directed bench for hd_program_loader (boot image, overflow copy).
// Revision : 1.0
// ============================================================================
module tb_hd_program_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start0, start1, hd_we_snoop;
  logic [7:0]  file_id;
  logic [9:0]  dest_base;
  logic [31:0] hd_mem [512];
  logic [8:0]  hd_addr0, hd_addr1, fsa0, fsa1;
  logic [31:0] hd_q0, hd_q1, mem_data0, mem_data1;
  logic [9:0]  mem_addr0;
  logic [5:0]  mem_addr1;
  logic        mem_we0, mem_we1, busy0, busy1, done0, done1;
  logic [2:0]  error0, error1;
  logic [10:0] word_count0;
  logic [6:0]  word_count1;
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [64];
  int          wr0 = 0, wr1 = 0;
  int          n_chk = 0, n_pass = 0;

  always @(posedge clk) begin
    hd_q0 <= hd_mem[hd_addr0];
    hd_q1 <= hd_mem[hd_addr1];
    if (mem_we0) begin mem0[mem_addr0] <= mem_data0; wr0 <= wr0 + 1; end
    if (mem_we1) begin mem1[mem_addr1] <= mem_data1; wr1 <= wr1 + 1; end
  end

  hd_program_loader dut0 (
    .clk(clk), .reset(reset), .start(start0), .file_id(file_id), .dest_base(dest_base),
    .hd_addr(hd_addr0), .hd_q(hd_q0), .hd_we_snoop(hd_we_snoop),
    .mem_addr(mem_addr0), .mem_data(mem_data0), .mem_we(mem_we0), .busy(busy0),
    .done(done0), .error(error0), .word_count(word_count0), .file_start_addr(fsa0));

  hd_program_loader #(.MEM_ADDR_WIDTH(6)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .file_id(file_id), .dest_base(dest_base[5:0]),
    .hd_addr(hd_addr1), .hd_q(hd_q1), .hd_we_snoop(hd_we_snoop),
    .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_we(mem_we1), .busy(busy1),
    .done(done1), .error(error1), .word_count(word_count1), .file_start_addr(fsa1));

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // lat = edge index (start edge = 0) at which done is sampled high, or the
  // edge that registered a nonzero error. A start with file_id=0 is pulsed at
  // cycle 'glitch' when nonzero, and must be ignored while busy.
  task automatic run_load(input bit sel, input logic [7:0] fid, input logic [9:0] base,
                          input int glitch, output int lat, output bit got_done, output int nwr);
    int cyc, w_0;
    @(negedge clk);
    file_id = fid; dest_base = base;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    w_0 = sel ? wr1 : wr0;
    @(posedge clk);
    cyc = 0; lat = -1; got_done = 1'b0;
    while (cyc < 400) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      if (glitch > 0 && cyc == glitch) begin
        file_id = 8'd0;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      if (sel ? done1 : done0) begin got_done = 1'b1; lat = cyc + 1; break; end
      if ((sel ? error1 : error0) != 3'd0) begin lat = cyc; break; end
      @(posedge clk);
      cyc++;
    end
    start0 = 1'b0; start1 = 1'b0;
    nwr = (sel ? wr1 : wr0) - w_0;
  endtask

  typedef struct {
    logic [7:0] fid;
    logic [9:0] base;
    int         exp_err;
    int         exp_wc;
    int         exp_fsa;
    int         exp_lat;
    bit         exp_done;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nwr;
    bit gd;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; hd_we_snoop = 1'b0;
    file_id = '0; dest_base = '0;
    for (int a = 0; a < 512; a++) hd_mem[a] = 32'(a);
    hd_mem[0]   = 32'h5400_0000;
    hd_mem[58]  = 32'h5400_0000 | 32'd58;
    hd_mem[83]  = 32'h5400_0000 | 32'd83;
    hd_mem[57]  = 32'h5800_0000 | 32'd57;
    hd_mem[82]  = 32'h5800_0000 | 32'd82;
    hd_mem[115] = 32'h5800_0000 | 32'd115;
    hd_mem[116] = 32'h6000_0000 | 32'd116;

    vecs[0] = '{8'd0, 10'd0,   0, 58,  0,  60, 1'b1};
    vecs[1] = '{8'd2, 10'd200, 0, 33, 83, 118, 1'b1};
    vecs[2] = '{8'd3, 10'd0,   1,  0, -1, 118, 1'b0};
    vecs[3] = '{8'd1, 10'd500, 0, 25, 58,  85, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_error", error0, 0);
    chk("rst_wc", word_count0, 0);
    chk("rst_hd_addr", hd_addr0, 0);
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_fsa", fsa0, 0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk) hd_we_snoop = 1'b1;
      @(negedge clk) hd_we_snoop = 1'b0;
      run_load(1'b0, vecs[i].fid, vecs[i].base, 0, lat, gd, nwr);
      chk($sformatf("v%0d_error", i), error0, vecs[i].exp_err);
      chk($sformatf("v%0d_wc", i), word_count0, vecs[i].exp_wc);
      chk($sformatf("v%0d_done", i), gd, vecs[i].exp_done);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wc);
      if (vecs[i].exp_fsa >= 0) chk($sformatf("v%0d_fsa", i), fsa0, vecs[i].exp_fsa);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done0, 0);
      chk($sformatf("v%0d_busy_after", i), busy0, 0);
    end
    chk("mem0_first", mem0[0], 32'h5400_0000);
    chk("mem0_mid", mem0[1], 32'd1);
    chk("mem0_last", mem0[57], 32'h5800_0039);
    chk("mem200", mem0[200], 32'h5400_0053);
    chk("mem232", mem0[232], 32'h5800_0073);
    chk("mem524", mem0[524], 32'h5800_0052);

    // Overflow: 6-bit memory, 24 words fit at 40..63 then the 25th faults.
    run_load(1'b1, 8'd0, 10'd40, 0, lat, gd, nwr);
    chk("ovf_error", error1, 3);
    chk("ovf_wc", word_count1, 24);
    chk("ovf_writes", nwr, 24);
    chk("ovf_done", gd, 0);
    chk("ovf_latency", lat, 26);
    chk("ovf_busy", busy1, 0);
    chk("ovf_mem40", mem1[40], 32'h5400_0000);
    chk("ovf_mem63", mem1[63], 32'd23);

    // Asynchronous reset while copying file 1, then a clean reload.
    @(negedge clk); file_id = 8'd1; dest_base = 10'd0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    repeat (70) @(posedge clk);
    #2;
    chk("mid_busy", busy0, 1);
    chk("mid_wc", word_count0, 11);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_wc", word_count0, 0);
    chk("arst_hd_addr", hd_addr0, 0);
    chk("arst_mem_we", mem_we0, 0);
    @(negedge clk) reset = 1'b0;
    run_load(1'b0, 8'd1, 10'd0, 20, lat, gd, nwr);
    chk("reload_wc", word_count0, 25);
    chk("reload_done", gd, 1);
    chk("reload_latency", lat, 85);
    chk("reload_fsa", fsa0, 58);
    chk("reload_error", error0, 0);

`ifdef HD_LOADER_DIR_CACHE_EN
    run_load(1'b0, 8'd2, 10'd300, 0, lat, gd, nwr);
    chk("dc_miss_latency", lat, 118);
    run_load(1'b0, 8'd2, 10'd300, 0, lat, gd, nwr);
    chk("dc_hit_latency", lat, 35);
    chk("dc_hit_wc", word_count0, 33);
    chk("dc_hit_fsa", fsa0, 83);
    @(negedge clk) hd_we_snoop = 1'b1;
    @(negedge clk) hd_we_snoop = 1'b0;
    run_load(1'b0, 8'd2, 10'd300, 0, lat, gd, nwr);
    chk("dc_snoop_latency", lat, 118);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
